// File: rtl/spad_dma_pkg.sv
// ============================================================================
// Module : spad_dma_pkg
// Brief  : Shared opcode, status and state encodings for the scratchpad DMA.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spad_dma_pkg;

  typedef enum logic [1:0] {
    OP_COPY = 2'd0,
    OP_FILL = 2'd1,
    OP_ADD  = 2'd2,
    OP_RSVD = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_RANGE_ERR = 2'd1,
    ST_ABORTED   = 2'd2,
    ST_BAD_OP    = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    FILLW = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spad_dma_addr_gen.sv
// ============================================================================
// Module : spad_dma_addr_gen
// Brief  : Base/length registers, word index, range check and last-word flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spad_dma_addr_gen #(
  parameter int OFFSET_SZ = 12
) (
  input  logic                 clk_ctrl,
  input  logic                 clk_ctrl_rst_high,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 check_src,
  input  logic [OFFSET_SZ-1:0] src_in,
  input  logic [OFFSET_SZ-1:0] dst_in,
  input  logic [OFFSET_SZ:0]   len_in,
  output logic                 range_err,
  output logic [OFFSET_SZ-1:0] rd_addr,
  output logic [OFFSET_SZ-1:0] wr_addr,
  output logic                 last
);

  localparam logic [OFFSET_SZ+1:0] SPAN = {2'b01, {OFFSET_SZ{1'b0}}};

  logic [OFFSET_SZ-1:0] src_base;
  logic [OFFSET_SZ-1:0] dst_base;
  logic [OFFSET_SZ:0]   len_q;
  logic [OFFSET_SZ:0]   idx;
  logic [OFFSET_SZ:0]   idx_next;
  logic [OFFSET_SZ+1:0] src_end;
  logic [OFFSET_SZ+1:0] dst_end;

  // One spare bit keeps a maximal len from wrapping the end-address sum.
  assign src_end   = {2'b00, src_in} + {1'b0, len_in};
  assign dst_end   = {2'b00, dst_in} + {1'b0, len_in};
  assign range_err = (check_src && (src_end > SPAN)) || (dst_end > SPAN);

  assign idx_next  = idx + {{OFFSET_SZ{1'b0}}, 1'b1};
  assign last      = (idx_next == len_q);
  assign rd_addr   = src_base + idx[OFFSET_SZ-1:0];
  assign wr_addr   = dst_base + idx[OFFSET_SZ-1:0];

  always_ff @(posedge clk_ctrl) begin
    if (clk_ctrl_rst_high) begin
      src_base <= '0;
      dst_base <= '0;
      len_q    <= '0;
      idx      <= '0;
    end else if (load) begin
      src_base <= src_in;
      dst_base <= dst_in;
      len_q    <= len_in;
      idx      <= '0;
    end else if (advance) begin
      idx      <= idx_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spad_dma_engine.sv
// ============================================================================
// Module : spad_dma_engine
// Brief  : COPY / FILL / ADD-immediate block mover on the scratchpad memory port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spad_dma_engine
  import spad_dma_pkg::*;
#(
  parameter int OFFSET_SZ = 12,
  parameter int DW        = 32
) (
  input  logic                 clk_ctrl,
  input  logic                 clk_ctrl_rst_high,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [OFFSET_SZ-1:0] cmd_src,
  input  logic [OFFSET_SZ-1:0] cmd_dst,
  input  logic [OFFSET_SZ:0]   cmd_len,
  input  logic [DW-1:0]        cmd_imm,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_status,
  output logic [OFFSET_SZ:0]   words_done,
  output logic                 mem_valid,
  output logic                 mem_wstrb,
  output logic [31:0]          mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_RD    = RD;
  localparam logic [2:0] S_WR    = WR;
  localparam logic [2:0] S_FILLW = FILLW;
  localparam logic [2:0] S_FIN   = FIN;

  logic [2:0]           state;
  logic [1:0]           op_q;
  logic [DW-1:0]        imm_q;
  logic [1:0]           status_q;
  logic [OFFSET_SZ:0]   words_q;
  logic [OFFSET_SZ-1:0] addr_word;

  logic                 accept;
  logic                 advance;
  logic                 range_err;
  logic                 last;
  logic [OFFSET_SZ-1:0] rd_addr;
  logic [OFFSET_SZ-1:0] wr_addr;

  assign accept  = cmd_valid && (state == S_IDLE);
  assign advance = (state == S_WR) || (state == S_FILLW);

  spad_dma_addr_gen #(
    .OFFSET_SZ (OFFSET_SZ)
  ) u_addr_gen (
    .clk_ctrl          (clk_ctrl),
    .clk_ctrl_rst_high (clk_ctrl_rst_high),
    .load              (accept),
    .advance           (advance),
    .check_src         (cmd_op != OP_FILL),
    .src_in            (cmd_src),
    .dst_in            (cmd_dst),
    .len_in            (cmd_len),
    .range_err         (range_err),
    .rd_addr           (rd_addr),
    .wr_addr           (wr_addr),
    .last              (last)
  );

  always_ff @(posedge clk_ctrl) begin
    if (clk_ctrl_rst_high) begin
      state    <= S_IDLE;
      op_q     <= '0;
      imm_q    <= '0;
      status_q <= ST_OK;
      words_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            imm_q   <= cmd_imm;
            words_q <= '0;
            if (cmd_op == OP_RSVD) begin
              state    <= S_FIN;
              status_q <= ST_BAD_OP;
            end else if (cmd_len == '0) begin
              state    <= S_FIN;
              status_q <= ST_OK;
            end else if (range_err) begin
              state    <= S_FIN;
              status_q <= ST_RANGE_ERR;
            end else if (cmd_op == OP_FILL) begin
              state    <= S_FILLW;
            end else begin
              state    <= S_RD;
            end
          end
        end
        S_RD: begin
          if (abort) begin
            state    <= S_FIN;
            status_q <= ST_ABORTED;
          end else begin
            state    <= S_WR;
          end
        end
        S_WR, S_FILLW: begin
          words_q <= words_q + {{OFFSET_SZ{1'b0}}, 1'b1};
          // Completing the final word takes precedence over a late abort.
          if (last) begin
            state    <= S_FIN;
            status_q <= ST_OK;
          end else if (abort) begin
            state    <= S_FIN;
            status_q <= ST_ABORTED;
          end else begin
            state    <= (state == S_WR) ? S_RD : S_FILLW;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_wstrb = 1'b0;
    addr_word = '0;
    mem_wdata = '0;
    case (state)
      S_RD: begin
        mem_valid = 1'b1;
        addr_word = rd_addr;
      end
      S_WR: begin
        mem_valid = 1'b1;
        mem_wstrb = 1'b1;
        addr_word = wr_addr;
        mem_wdata = (op_q == OP_ADD) ? (mem_rdata + imm_q) : mem_rdata;
      end
      S_FILLW: begin
        mem_valid = 1'b1;
        mem_wstrb = 1'b1;
        addr_word = wr_addr;
        mem_wdata = imm_q;
      end
      default: begin
        mem_valid = 1'b0;
      end
    endcase
  end

  assign mem_addr    = {{(32-OFFSET_SZ){1'b0}}, addr_word};
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);
  assign done_status = status_q;
  assign words_done  = words_q;

endmodule

`default_nettype wire

// File: tb/tb_spad_dma_engine.sv
// ============================================================================
// Module : tb_spad_dma_engine
// Brief  : Directed self-checking bench for spad_dma_engine with a 1-cycle memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spad_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_src;
  logic [11:0] cmd_dst;
  logic [12:0] cmd_len;
  logic [31:0] cmd_imm;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  done_status;
  logic [12:0] words_done;
  logic        mem_valid;
  logic        mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  logic [31:0] mem [0:4095];
  logic        log_we   [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spad_dma_engine #(.OFFSET_SZ(12), .DW(32)) dut (
    .clk_ctrl          (clk),
    .clk_ctrl_rst_high (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_src           (cmd_src),
    .cmd_dst           (cmd_dst),
    .cmd_len           (cmd_len),
    .cmd_imm           (cmd_imm),
    .abort             (abort),
    .busy              (busy),
    .done              (done),
    .done_status       (done_status),
    .words_done        (words_done),
    .mem_valid         (mem_valid),
    .mem_wstrb         (mem_wstrb),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata)
  );

  // Memory with registered read data, plus a bench-side preload port and access log.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_valid) begin
      log_we.push_back(mem_wstrb);
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      if (mem_wstrb) mem[mem_addr[11:0]] <= mem_wdata;
      else           mem_rdata <= mem[mem_addr[11:0]];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] src, input logic [11:0] dst,
                       input logic [12:0] len, input logic [31:0] imm);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc >= 300) begin
        checks++; errors++;
        $display("FAIL done_timeout: got no done after %0d cycles required done", cyc);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    cmd_imm = '0; abort = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (mem_valid !== 1'b0 || mem_wstrb !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl: got %b%b expected 00", mem_valid, mem_wstrb); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    checks++; if (words_done !== 13'd0 || done_status !== 2'd0) begin errors++; $display("FAIL reset_status: got %0d/%0d expected 0/0", words_done, done_status); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_copy();
    int c; int base;
    logic [31:0] exp_w;
    logic [31:0] exp_a;
    for (int i = 0; i < 4; i++) preload(12'h010 + 12'(i), 32'hA000_0001 + 32'(i));
    base = log_we.size();
    issue(2'd0, 12'h010, 12'h100, 13'd4, 32'h0);
    wait_done(c);
    checks++; if (c !== 9) begin errors++; $display("FAIL copy_latency: got %0d expected 9", c); end
    checks++; if (done_status !== 2'd0) begin errors++; $display("FAIL copy_status: got %0d expected 0", done_status); end
    checks++; if (words_done !== 13'd4) begin errors++; $display("FAIL copy_words: got %0d expected 4", words_done); end
    checks++; if (log_we.size() - base !== 8) begin errors++; $display("FAIL copy_access_count: got %0d expected 8", log_we.size() - base); end
    if (log_we.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        exp_w = (i % 2 == 1) ? 32'd1 : 32'd0;
        exp_a = (i % 2 == 1) ? 32'h100 + 32'(i / 2) : 32'h010 + 32'(i / 2);
        checks++;
        if ({31'd0, log_we[base+i]} !== exp_w || log_addr[base+i] !== exp_a) begin
          errors++;
          $display("FAIL copy_seq[%0d]: got we=%b addr=%h expected we=%0d addr=%h", i, log_we[base+i], log_addr[base+i], exp_w, exp_a);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[12'h100 + 12'(i)] !== 32'hA000_0001 + 32'(i)) begin
        errors++;
        $display("FAIL copy_data[%0d]: got %h expected %h", i, mem[12'h100 + 12'(i)], 32'hA000_0001 + 32'(i));
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL copy_after_done: got done=%b busy=%b ready=%b expected 0 0 1", done, busy, cmd_ready); end
  endtask

  task automatic test_fill();
    int c; int base;
    base = log_we.size();
    issue(2'd1, 12'h000, 12'hFFC, 13'd4, 32'hDEAD_BEEF);
    wait_done(c);
    checks++; if (c !== 5) begin errors++; $display("FAIL fill_latency: got %0d expected 5", c); end
    checks++; if (done_status !== 2'd0 || words_done !== 13'd4) begin errors++; $display("FAIL fill_status: got %0d/%0d expected 0/4", done_status, words_done); end
    checks++; if (log_we.size() - base !== 4) begin errors++; $display("FAIL fill_access_count: got %0d expected 4", log_we.size() - base); end
    if (log_we.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_we[base+i] !== 1'b1 || log_addr[base+i] !== 32'hFFC + 32'(i) || log_data[base+i] !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL fill_seq[%0d]: got we=%b addr=%h data=%h expected 1 %h deadbeef", i, log_we[base+i], log_addr[base+i], log_data[base+i], 32'hFFC + 32'(i));
        end
      end
    end
    base = log_we.size();
    issue(2'd1, 12'h000, 12'hFFC, 13'd5, 32'hDEAD_BEEF);
    wait_done(c);
    checks++; if (done_status !== 2'd1) begin errors++; $display("FAIL fill_range_status: got %0d expected 1", done_status); end
    checks++; if (c !== 1) begin errors++; $display("FAIL fill_range_latency: got %0d expected 1", c); end
    checks++; if (log_we.size() - base !== 0) begin errors++; $display("FAIL fill_range_access: got %0d expected 0", log_we.size() - base); end
  endtask

  task automatic test_add();
    int c;
    preload(12'h020, 32'hFFFF_FFFF);
    preload(12'h021, 32'h0000_0005);
    issue(2'd2, 12'h020, 12'h020, 13'd2, 32'h1);
    wait_done(c);
    checks++; if (done_status !== 2'd0 || c !== 5) begin errors++; $display("FAIL add_status: got status=%0d cyc=%0d expected 0 5", done_status, c); end
    checks++; if (mem[12'h020] !== 32'h0) begin errors++; $display("FAIL add_carry: got %h expected 00000000", mem[12'h020]); end
    checks++; if (mem[12'h021] !== 32'h6) begin errors++; $display("FAIL add_word1: got %h expected 00000006", mem[12'h021]); end
  endtask

  task automatic test_len0();
    int c; int base;
    base = log_we.size();
    issue(2'd0, 12'h010, 12'h100, 13'd0, 32'h0);
    wait_done(c);
    checks++; if (c !== 1) begin errors++; $display("FAIL len0_latency: got %0d expected 1", c); end
    checks++; if (done_status !== 2'd0 || words_done !== 13'd0) begin errors++; $display("FAIL len0_status: got %0d/%0d expected 0/0", done_status, words_done); end
    checks++; if (log_we.size() - base !== 0) begin errors++; $display("FAIL len0_access: got %0d expected 0", log_we.size() - base); end
  endtask

  task automatic test_abort();
    int base; int nwr; int bad;
    for (int i = 0; i < 8; i++) preload(12'h200 + 12'(i), 32'h0000_1000 + 32'(i));
    preload(12'h303, 32'h5A5A_5A5A);
    base = log_we.size();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_src = 12'h200; cmd_dst = 12'h300; cmd_len = 13'd8; cmd_imm = '0;
    @(posedge clk); #1;
    // keep offering a different command while the engine is busy
    cmd_op = 2'd1; cmd_dst = 12'h500; cmd_len = 13'd1; cmd_imm = 32'hBAD;
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b expected 1", done); end
    checks++; if (done_status !== 2'd2) begin errors++; $display("FAIL abort_status: got %0d expected 2", done_status); end
    checks++; if (words_done !== 13'd3) begin errors++; $display("FAIL abort_words: got %0d expected 3", words_done); end
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    nwr = 0; bad = 0;
    for (int i = base; i < log_we.size(); i++) begin
      if (log_we[i]) nwr++;
      if (log_addr[i] == 32'h500) bad++;
    end
    checks++; if (log_we.size() - base !== 6) begin errors++; $display("FAIL abort_access_count: got %0d expected 6", log_we.size() - base); end
    checks++; if (nwr !== 3) begin errors++; $display("FAIL abort_writes: got %0d expected 3", nwr); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_cmd_ignored: got %0d expected 0", bad); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[12'h300 + 12'(i)] !== 32'h0000_1000 + 32'(i)) begin
        errors++;
        $display("FAIL abort_data[%0d]: got %h expected %h", i, mem[12'h300 + 12'(i)], 32'h0000_1000 + 32'(i));
      end
    end
    checks++; if (mem[12'h303] !== 32'h5A5A_5A5A) begin errors++; $display("FAIL abort_untouched: got %h expected 5a5a5a5a", mem[12'h303]); end
  endtask

  task automatic test_abort_last();
    issue(2'd1, 12'h000, 12'h600, 13'd2, 32'h7);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_last_done: got %b expected 1", done); end
    checks++; if (done_status !== 2'd0 || words_done !== 13'd2) begin errors++; $display("FAIL abort_last_status: got %0d/%0d expected 0/2", done_status, words_done); end
    checks++; if (mem[12'h601] !== 32'h7) begin errors++; $display("FAIL abort_last_data: got %h expected 00000007", mem[12'h601]); end
  endtask

  task automatic test_bad_op();
    int c; int base;
    base = log_we.size();
    issue(2'd3, 12'h000, 12'h000, 13'd4, 32'h0);
    wait_done(c);
    checks++; if (done_status !== 2'd3 || c !== 1) begin errors++; $display("FAIL bad_op: got status=%0d cyc=%0d expected 3 1", done_status, c); end
    checks++; if (log_we.size() - base !== 0) begin errors++; $display("FAIL bad_op_access: got %0d expected 0", log_we.size() - base); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    issue(2'd1, 12'h000, 12'h400, 13'd16, 32'h77);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL reset_mid_active: got %b expected 1", mem_valid); end
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mid_mem: got %b/%h expected 0/0", mem_valid, mem_wdata); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid_ctl: got ready=%b busy=%b done=%b expected 1 0 0", cmd_ready, busy, done); end
    checks++; if (words_done !== 13'd0 || done_status !== 2'd0) begin errors++; $display("FAIL reset_mid_status: got %0d/%0d expected 0/0", words_done, done_status); end
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d expected 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_add();
    test_len0();
    test_abort();
    test_abort_last();
    test_bad_op();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
